// File: rtl/fl_mode_reg_if.sv
// Control and data bundle for fl_mode_reg: load sources, mode controls and register outputs.
interface fl_mode_reg_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned SEL_W  = 1
);
   logic                      SP;
   logic                      PS;
   logic [1:0]                MODE;
   logic [SEL_W-1:0]          SEL;
   logic [NUM_IN*WIDTH-1:0]   D;
   logic                      DIR;
   logic                      SI;
   logic [WIDTH-1:0]          Q;
   logic                      SO;
   logic                      TC;

   modport master (
      output SP, PS, MODE, SEL, D, DIR, SI,
      input  Q, SO, TC
   );

   modport slave (
      input  SP, PS, MODE, SEL, D, DIR, SI,
      output Q, SO, TC
   );
endinterface

// File: rtl/fl_mode_reg.sv
// Multi-source register with clock enable, preset, shift and up/down count (wrap or saturate).
// Priority per edge: reset > preset > enable > mode.
module fl_mode_reg #(
   parameter int unsigned     WIDTH   = 8,
   parameter int unsigned     NUM_IN  = 2,
   parameter int unsigned     SEL_W   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter logic [WIDTH-1:0] PRE_VAL = '1,
   parameter bit              SAT     = 1'b0
) (
   input  logic              CK,
   input  logic              CDN,
   fl_mode_reg_if.slave      bus
);
   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;
   localparam logic [1:0] MODE_COUNT = 2'b11;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             at_max;
   logic             at_min;

   assign at_max = &q_q;
   assign at_min = ~|q_q;

   // Next-state selection; unmatched SEL values fall through to hold.
   always_comb begin
      q_d = q_q;
      if (bus.PS) begin
         q_d = PRE_VAL;
      end else if (bus.SP) begin
         case (bus.MODE)
            MODE_HOLD: q_d = q_q;
            MODE_LOAD: begin
               for (int unsigned k = 0; k < NUM_IN; k++) begin
                  if (bus.SEL == SEL_W'(k)) q_d = bus.D[k*WIDTH +: WIDTH];
               end
            end
            MODE_SHIFT: begin
               if (bus.DIR) q_d = {bus.SI, q_q[WIDTH-1:1]};
               else         q_d = {q_q[WIDTH-2:0], bus.SI};
            end
            MODE_COUNT: begin
               if (!bus.DIR) begin
                  if (!(SAT && at_max)) q_d = q_q + WIDTH'(1);
               end else begin
                  if (!(SAT && at_min)) q_d = q_q - WIDTH'(1);
               end
            end
            default: q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge CK) begin
      if (!CDN) q_q <= RST_VAL;
      else      q_q <= q_d;
   end

   assign bus.Q  = q_q;
   assign bus.SO = bus.DIR ? q_q[0] : q_q[WIDTH-1];
   assign bus.TC = bus.SP & ~bus.PS & CDN & (bus.MODE == MODE_COUNT) &
                   ((~bus.DIR & at_max) | (bus.DIR & at_min));
endmodule
